// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port out, bundled for the boot loader.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 12
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   modport master (output in_data, in_valid, input in_ready, wr_en, wr_addr, wr_data);
   modport slave  (input in_data, in_valid, output in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte frame into instruction-memory writes.
//   state  | meaning
//   IDLE   | waiting for start, CPU running
//   LEN_HI | expecting length high byte
//   LEN_LO | expecting length low byte, range check
//   INS_HI | expecting instruction high byte
//   INS_LO | expecting instruction low byte, issues write
//   CHK    | expecting checksum byte
//   DONE   | frame good, CPU may be released
//   ERR    | frame bad (too long or checksum), memory left as written
module imem_loader #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_INS_HI, S_INS_LO, S_CHK, S_DONE, S_ERR
   } state_t;

   localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

   state_t                r_state, w_next;
   logic [7:0]            r_len_hi;
   logic [15:0]           r_remain;
   logic [DATA_WIDTH-9:0] r_hi;
   logic [7:0]            r_chk;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;

   logic                  w_busy;
   logic                  w_accept;
   logic                  w_start_ok;
   logic [16:0]           w_len;
   logic [DATA_WIDTH-1:0] w_word;

   assign w_len  = {1'b0, r_len_hi, bus.in_data};
   assign w_word = {r_hi, bus.in_data};

   always_comb begin
      w_next     = r_state;
      w_busy     = 1'b0;
      w_start_ok = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            w_start_ok = start;
            if (start) w_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            w_busy = 1'b1;
            if (bus.in_valid) w_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            w_busy = 1'b1;
            if (bus.in_valid) begin
               if (w_len > DEPTH)       w_next = S_ERR;
               else if (w_len == 17'd0) w_next = S_CHK;
               else                     w_next = S_INS_HI;
            end
         end
         S_INS_HI: begin
            w_busy = 1'b1;
            if (bus.in_valid) w_next = S_INS_LO;
         end
         S_INS_LO: begin
            w_busy = 1'b1;
            if (bus.in_valid) w_next = (r_remain == 16'd1) ? S_CHK : S_INS_HI;
         end
         S_CHK: begin
            w_busy = 1'b1;
            if (bus.in_valid) w_next = (bus.in_data == r_chk) ? S_DONE : S_ERR;
         end
         default: w_next = S_IDLE;
      endcase
      w_accept = w_busy & bus.in_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_len_hi  <= '0;
         r_remain  <= '0;
         r_hi      <= '0;
         r_chk     <= '0;
         r_addr    <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_state <= w_next;
         r_wr_en <= 1'b0;
         if (w_start_ok) begin
            r_addr <= '0;
            r_chk  <= '0;
         end
         if (w_accept) begin
            case (r_state)
               S_LEN_HI: r_len_hi <= bus.in_data;
               S_LEN_LO: r_remain <= w_len[15:0];
               S_INS_HI: begin
                  r_hi  <= bus.in_data[DATA_WIDTH-9:0];
                  r_chk <= r_chk ^ bus.in_data;
               end
               S_INS_LO: begin
                  // at N = depth the address wraps to 0 after the last write; harmless
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_addr;
                  r_wr_data <= w_word;
                  r_addr    <= r_addr + 1'b1;
                  r_remain  <= r_remain - 16'd1;
                  r_chk     <= r_chk ^ bus.in_data;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready = w_busy;
   assign bus.wr_en    = r_wr_en;
   assign bus.wr_addr  = r_wr_addr;
   assign bus.wr_data  = r_wr_data;
   assign cpu_hold     = w_busy;
   assign done         = (r_state == S_DONE);
   assign err          = (r_state == S_ERR);
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, directed corner cases and random frames vs. a frame-level model.
module tb_imem_loader;
   localparam int AW = 9;
   localparam int DW = 12;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int         nb;
      logic [7:0] by [0:9];
      bit         exp_done;
      bit         exp_err;
      int         exp_nw;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic cpu_hold, done, err;

   imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

   imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bus      (ifc.slave),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int wq[$];
   int exp_w[$];
   bit exp_done, exp_err;
   int exp_len;
   bit prev_wr = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // write monitor; wr_en must never be high on two consecutive cycles
   always @(negedge clk) begin
      if (ifc.wr_en) begin
         wq.push_back((int'(ifc.wr_addr) << 16) | int'(ifc.wr_data));
         checks++;
         if (prev_wr) begin
            errors++;
            $display("FAIL wr_pulse: got 2-cycle wr_en expected 1-cycle at addr 0x%0h", ifc.wr_addr);
         end
      end
      prev_wr = ifc.wr_en;
   end

   // frame-level reference: what writes and what verdict the frame deserves
   task automatic model(input bq_t fr);
      int n;
      logic [7:0] x;
      exp_w.delete();
      n = int'(fr[0]) * 256 + int'(fr[1]);
      if (n > (1 << AW)) begin
         exp_done = 0; exp_err = 1; exp_len = 2;
      end else begin
         x = 8'h00;
         for (int i = 0; i < n; i++) begin
            exp_w.push_back((i << 16) | (((int'(fr[2+2*i]) << 8) | int'(fr[3+2*i])) & ((1 << DW) - 1)));
            x = x ^ fr[2+2*i] ^ fr[3+2*i];
         end
         exp_len  = 3 + 2 * n;
         exp_done = (fr[2+2*n] == x);
         exp_err  = !exp_done;
      end
   endtask

   task automatic send_bytes(input bq_t fr, input int n, input bit gaps, input bit start_mid);
      int to;
      for (int k = 0; k < n; k++) begin
         while ((gaps && $urandom_range(0, 2) == 0) || (start_mid && k == 3)) begin
            ifc.in_valid = 1'b0;
            ifc.in_data  = 8'($urandom);
            start = start_mid && (k == 3 || $urandom_range(0, 1) == 1);
            @(negedge clk);
            start = 1'b0;
            if (k == 3) break;
         end
         ifc.in_valid = 1'b1;
         ifc.in_data  = fr[k];
         to = 0;
         while (!ifc.in_ready) begin
            @(negedge clk);
            to++;
            if (to > 20) break;
         end
         if (to > 20) begin
            check("ready_timeout", 0, 1);
            break;
         end
         @(negedge clk);
      end
      ifc.in_valid = 1'b0;
   endtask

   task automatic run_frame(input bq_t fr, input bit gaps, input bit start_mid, input string name);
      model(fr);
      @(negedge clk);
      wq.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, ".hold_on"}, int'(cpu_hold), 1);
      send_bytes(fr, exp_len, gaps, start_mid);
      repeat (2) @(negedge clk);
      check({name, ".done"}, int'(done), int'(exp_done));
      check({name, ".err"}, int'(err), int'(exp_err));
      check({name, ".hold_off"}, int'(cpu_hold), 0);
      check({name, ".ready_off"}, int'(ifc.in_ready), 0);
      check({name, ".nwrites"}, wq.size(), exp_w.size());
      for (int i = 0; i < wq.size() && i < exp_w.size(); i++)
         check({name, ".write"}, wq[i], exp_w[i]);
   endtask

   vec_t tbl[6];
   bq_t fr;

   initial begin
      ifc.in_valid = 1'b0;
      ifc.in_data  = 8'h00;

      tbl[0] = '{9, '{8'h00,8'h03,8'h01,8'h41,8'h04,8'h8B,8'h0A,8'h01,8'hC4,8'h00}, 1, 0, 3};
      tbl[1] = '{9, '{8'h00,8'h03,8'h01,8'h41,8'h04,8'h8B,8'h0A,8'h01,8'hC5,8'h00}, 0, 1, 3};
      tbl[2] = '{2, '{8'h02,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 1, 0};
      tbl[3] = '{3, '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 0, 0};
      tbl[4] = '{3, '{8'h00,8'h00,8'h7F,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 1, 0};
      tbl[5] = '{5, '{8'h00,8'h01,8'hFF,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 0, 1};

      #2;
      check("rst.ready", int'(ifc.in_ready), 0);
      check("rst.wr_en", int'(ifc.wr_en), 0);
      check("rst.hold", int'(cpu_hold), 0);
      check("rst.done", int'(done), 0);
      check("rst.err", int'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle.ready", int'(ifc.in_ready), 0);

      foreach (tbl[t]) begin
         fr.delete();
         for (int i = 0; i < tbl[t].nb; i++) fr.push_back(tbl[t].by[i]);
         run_frame(fr, 1'b0, 1'b0, $sformatf("vec%0d", t));
         check($sformatf("vec%0d.tbl_done", t), int'(done), int'(tbl[t].exp_done));
         check($sformatf("vec%0d.tbl_err", t), int'(err), int'(tbl[t].exp_err));
         check($sformatf("vec%0d.tbl_nw", t), wq.size(), tbl[t].exp_nw);
      end

      // gapped stream with stray start pulses must give the same three writes
      fr.delete();
      for (int i = 0; i < 9; i++) fr.push_back(tbl[0].by[i]);
      run_frame(fr, 1'b1, 1'b1, "gapped");
      if (wq.size() == 3) begin
         check("gapped.w0", wq[0], 32'h0000_0141);
         check("gapped.w1", wq[1], 32'h0001_048B);
         check("gapped.w2", wq[2], 32'h0002_0A01);
      end else check("gapped.count", wq.size(), 3);

      // reset after the first write of the reference frame
      @(negedge clk);
      wq.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_bytes(fr, 4, 1'b0, 1'b0);
      @(negedge clk);
      check("mid.nw", wq.size(), 1);
      check("mid.wr_data", int'(ifc.wr_data), 32'h141);
      #2 rst_n = 1'b0;
      #1;
      check("mid.ready", int'(ifc.in_ready), 0);
      check("mid.wr_en", int'(ifc.wr_en), 0);
      check("mid.wr_addr", int'(ifc.wr_addr), 0);
      check("mid.wr_data0", int'(ifc.wr_data), 0);
      check("mid.hold", int'(cpu_hold), 0);
      check("mid.done", int'(done) | int'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(fr, 1'b0, 1'b0, "after_rst");

      // largest legal frame: 512 instructions, last write at 511
      fr.delete();
      fr.push_back(8'h02); fr.push_back(8'h00);
      begin
         logic [7:0] x = 8'h00;
         for (int i = 0; i < 1024; i++) begin
            fr.push_back(8'($urandom));
            x = x ^ fr[fr.size()-1];
         end
         fr.push_back(x);
      end
      run_frame(fr, 1'b0, 1'b0, "full");
      if (wq.size() > 0) check("full.last_addr", wq[wq.size()-1] >>> 16, 511);

      // random frames, some corrupted, some oversize
      for (int r = 0; r < 40; r++) begin
         int n;
         logic [7:0] x;
         fr.delete();
         if (r % 10 == 9) begin
            n = $urandom_range(513, 65535);
            fr.push_back(8'(n >> 8)); fr.push_back(8'(n));
         end else begin
            n = $urandom_range(0, 6);
            fr.push_back(8'(n >> 8)); fr.push_back(8'(n));
            x = 8'h00;
            for (int i = 0; i < 2 * n; i++) begin
               fr.push_back(8'($urandom));
               x = x ^ fr[fr.size()-1];
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            fr.push_back(x);
         end
         run_frame(fr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, instruction-memory address width; depth = 1<<ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, instruction width; legal range 9..16.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-004 SHALL have port start, input, 1: pulse that begins a load when idle.
REQ-005 SHALL have port in_data, input, 8: stream byte.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_ready, output, 1: loader can accept a byte.
REQ-008 SHALL have port wr_en, output, 1: instruction-memory write strobe.
REQ-009 SHALL have port wr_addr, output, ADDR_WIDTH: write address.
REQ-010 SHALL have port wr_data, output, DATA_WIDTH: instruction word to write.
REQ-011 SHALL have port cpu_hold, output, 1: high while a load is in progress; CPU is held in reset.
REQ-012 SHALL have port done, output, 1: last load completed with a good checksum.
REQ-013 SHALL have port err, output, 1: last load failed.

Function
REQ-014 SHALL accept a byte only on a rising clk edge where in_valid and in_ready are both high.
REQ-015 SHALL use frame format: LEN_HI, LEN_LO (16-bit N, big-endian), then N instructions of 2 bytes each (HI, LO), then 1 checksum byte.
REQ-016 SHALL form each instruction as {HI,LO}[DATA_WIDTH-1:0]; unused HI bits are ignored.
REQ-017 SHALL compute the checksum as the XOR of all 2N instruction bytes, with an initial value of 0x00; length bytes are excluded.
REQ-018 SHALL implement the FSM states IDLE, LEN_HI, LEN_LO, INS_HI, INS_LO, CHK, DONE, ERR.
REQ-019 SHALL hold in_ready high in states LEN_HI, LEN_LO, INS_HI, INS_LO, CHK and low in IDLE, DONE, ERR.
REQ-020 SHALL take these transitions on start while in IDLE, DONE or ERR: go to LEN_HI; clear done, err, the address counter and the checksum.
REQ-021 SHALL ignore start while in any other state.
REQ-022 SHALL go from LEN_LO to ERR when N > 1<<ADDR_WIDTH, to CHK when N = 0, and to INS_HI otherwise.
REQ-023 SHALL drive wr_en high for exactly one cycle, in the cycle after the LO byte is accepted, with wr_addr equal to the instruction index (0..N-1) and wr_data equal to the assembled word.
REQ-024 SHALL increment the address counter after each write; when N = 1<<ADDR_WIDTH the last write is at address depth-1 and the counter wraps without effect.
REQ-025 SHALL go from INS_LO to CHK after the Nth instruction and to INS_HI otherwise.
REQ-026 SHALL, in CHK, go to DONE (done=1) when the accepted byte equals the running XOR, and to ERR (err=1) otherwise.
REQ-027 SHALL hold done and err until the next accepted start or reset.
REQ-028 SHALL hold cpu_hold high in states LEN_HI through CHK and low otherwise.
REQ-029 SHALL NOT roll back memory contents on ERR; the CPU must not be released until done=1.
REQ-030 SHALL accept back-to-back bytes (in_valid held high) at one byte per cycle with no bubbles.
REQ-031 SHALL insert no wait cycles while in_valid is low; the FSM holds its state.

Reset
REQ-032 SHALL, while rst_n=0, immediately force state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, err=0, and clear the counters and checksum.
REQ-033 SHALL, on reset mid-load, abandon the frame; any partial writes remain in memory; a new start is required.

Verification
REQ-034 SHALL cover: start; bytes 00 03 | 01 41 | 04 8B | 0A 01 | checksum 0xC4 -> writes (0,0x141), (1,0x48B), (2,0xA01) on 3 single-cycle wr_en pulses; done=1; cpu_hold falls.
REQ-035 SHALL cover: same frame with checksum 0xC5 -> 3 writes occur; err=1; done=0.
REQ-036 SHALL cover: bytes 02 01 with ADDR_WIDTH=9 (N=513) -> err=1 after LEN_LO; no wr_en; in_ready=0.
REQ-037 SHALL cover: N=0 frame 00 00 00 -> done=1 and no writes; 00 00 7F -> err=1.
REQ-038 SHALL cover: rst_n pulsed low after the first write of the REQ-034 frame -> all outputs 0 asynchronously; a following start and full frame completes with done=1.
REQ-039 SHALL cover: in_valid toggling randomly and start pulsed mid-load -> identical writes to REQ-034 and start ignored.
